// File: rtl/generador_trama.sv
// Serial frame generator: header codeword, buffered 5-bit payload words,
// filler headers while idle, and a loss-of-sync codeword on request.
module generador_trama #(
    parameter logic [4:0] SECUENCIA    = 5'b10100,
    parameter logic [4:0] SEC_REINICIO = 5'b00000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] dato_in,
    input  logic       dato_valido,
    input  logic       fin,
    output logic       listo,
    output logic       s_out,
    output logic       sincronizado,
    output logic       error
);

    typedef enum logic [1:0] {
        INACTIVO,
        SYNC,
        DATOS,
        REINICIO
    } estado_t;

    estado_t    estado, estado_sig;
    logic [2:0] idx, idx_sig, idx_m1;
    logic [4:0] shreg, shreg_sig;
    logic [4:0] buffer, buffer_sig;
    logic       buf_lleno, buf_lleno_sig;
    logic       fin_pend, fin_pend_sig;
    logic       s_out_sig, error_sig;
    logic       acepta, rechazo;
    logic       cargar;
    logic [4:0] carga;

    assign listo        = !buf_lleno && (estado != REINICIO);
    assign sincronizado = (estado != INACTIVO);
    assign acepta  = dato_valido && listo && (dato_in != SEC_REINICIO);
    assign rechazo = dato_valido && listo && (dato_in == SEC_REINICIO);
    assign idx_m1  = idx - 3'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado    <= INACTIVO;
            idx       <= 3'd4;
            shreg     <= '0;
            buffer    <= '0;
            buf_lleno <= 1'b0;
            fin_pend  <= 1'b0;
            s_out     <= 1'b0;
            error     <= 1'b0;
        end else begin
            estado    <= estado_sig;
            idx       <= idx_sig;
            shreg     <= shreg_sig;
            buffer    <= buffer_sig;
            buf_lleno <= buf_lleno_sig;
            fin_pend  <= fin_pend_sig;
            s_out     <= s_out_sig;
            error     <= error_sig;
        end
    end

    always_comb begin
        estado_sig    = estado;
        idx_sig       = idx;
        shreg_sig     = shreg;
        buffer_sig    = buffer;
        buf_lleno_sig = buf_lleno;
        fin_pend_sig  = fin_pend;
        s_out_sig     = s_out;
        error_sig     = rechazo;
        cargar        = 1'b0;
        carga         = SECUENCIA;

        if (acepta) begin
            buffer_sig    = dato_in;
            buf_lleno_sig = 1'b1;
        end
        if (fin && (estado == SYNC || estado == DATOS))
            fin_pend_sig = 1'b1;

        unique case (estado)
            INACTIVO: begin
                s_out_sig = 1'b0;
                idx_sig   = 3'd4;
                if (acepta) begin
                    estado_sig = SYNC;
                    cargar     = 1'b1;
                end
            end
            SYNC, DATOS: begin
                if (idx != 3'd0) begin
                    idx_sig   = idx_m1;
                    s_out_sig = shreg[idx_m1];
                // A word arriving on the last bit edge bypasses the buffer
                end else if (buf_lleno || acepta) begin
                    estado_sig    = DATOS;
                    cargar        = 1'b1;
                    carga         = buf_lleno ? buffer : dato_in;
                    buf_lleno_sig = 1'b0;
                end else if (fin_pend || fin) begin
                    estado_sig = REINICIO;
                    cargar     = 1'b1;
                    carga      = SEC_REINICIO;
                end else begin
                    estado_sig = SYNC;
                    cargar     = 1'b1;
                end
            end
            REINICIO: begin
                if (idx != 3'd0) begin
                    idx_sig   = idx_m1;
                    s_out_sig = shreg[idx_m1];
                end else begin
                    estado_sig   = INACTIVO;
                    s_out_sig    = 1'b0;
                    fin_pend_sig = 1'b0;
                    idx_sig      = 3'd4;
                end
            end
            default: estado_sig = INACTIVO;
        endcase

        if (cargar) begin
            shreg_sig = carga;
            s_out_sig = carga[4];
            idx_sig   = 3'd4;
        end
    end

endmodule

// File: tb/tb_generador_trama.sv
// Bench for generador_trama: vector table, hand sequences, random vs model.
module tb_generador_trama;

    localparam logic [4:0] SEC = 5'b10100;
    localparam logic [4:0] SR  = 5'b00000;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] dato_in;
    logic       dato_valido;
    logic       fin;
    logic       listo, s_out, sincronizado, error;

    int checks = 0;
    int errors = 0;

    generador_trama #(.SECUENCIA(SEC), .SEC_REINICIO(SR)) dut (
        .clk(clk), .rst(rst), .dato_in(dato_in),
        .dato_valido(dato_valido), .fin(fin), .listo(listo),
        .s_out(s_out), .sincronizado(sincronizado), .error(error)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of bits still to send plus pending words
    int         mmode;
    bit         mq[$];
    bit [4:0]   mpend[$];
    bit         mfin;
    bit         exp_s, exp_err;

    function automatic void m_reset();
        mmode = 0;
        mq.delete();
        mpend.delete();
        mfin = 0;
        exp_s = 0;
        exp_err = 0;
    endfunction

    function automatic void push_word(input bit [4:0] w);
        for (int i = 4; i >= 0; i--) mq.push_back(w[i]);
    endfunction

    function automatic bit m_listo();
        return (mpend.size() == 0) && (mmode != 2);
    endfunction

    function automatic void m_step(input bit v, input bit [4:0] d,
                                   input bit f);
        bit lis, acc;
        lis = m_listo();
        acc = v && lis && (d != SR);
        exp_err = v && lis && (d == SR);
        if (mmode == 1 && f) mfin = 1;
        if (acc) mpend.push_back(d);
        if (mmode == 0) begin
            if (acc) begin
                mmode = 1;
                push_word(SEC);
            end
        end else if (mq.size() == 0) begin
            if (mmode == 2) begin
                mmode = 0;
                mfin = 0;
            end else if (mpend.size() > 0) begin
                push_word(mpend.pop_front());
            end else if (mfin) begin
                mmode = 2;
                push_word(SR);
            end else begin
                push_word(SEC);
            end
        end
        if (mmode == 0) exp_s = 0;
        else exp_s = mq.pop_front();
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic v,
                       input logic [4:0] d, input logic f);
        @(negedge clk);
        rst = r;
        dato_valido = v;
        dato_in = d;
        fin = f;
        if (r) m_reset();
        else m_step(v, d, f);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 5'd0, 1'b0);
        cyc(1'b1, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic       v;
        logic [4:0] d;
        logic       f;
        logic       s;
        logic       y;
        logic       l;
        logic       e;
    } vec_t;

    vec_t tab[18];

    logic [19:0] got;

    initial begin
        tab[0]  = '{1'b1, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tab[1]  = '{1'b0, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tab[2]  = '{1'b1, 5'b01110, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tab[3]  = '{1'b0, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tab[4]  = '{1'b0, 5'b00000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tab[5]  = '{1'b0, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tab[6]  = '{1'b0, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tab[7]  = '{1'b0, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tab[8]  = '{1'b0, 5'b00000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tab[9]  = '{1'b0, 5'b00000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tab[10] = '{1'b0, 5'b00000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tab[11] = '{1'b0, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tab[12] = '{1'b0, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tab[13] = '{1'b0, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tab[14] = '{1'b0, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tab[15] = '{1'b0, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tab[16] = '{1'b0, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tab[17] = '{1'b0, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        rst = 1'b1;
        dato_valido = 1'b0;
        dato_in = 5'd0;
        fin = 1'b0;
        m_reset();
        #1;
        chk("rst_sout_t0", s_out, 0);
        chk("rst_listo_t0", listo, 1);
        do_reset();
        #1;
        chk("rel_sout", s_out, 0);
        chk("rel_listo", listo, 1);
        chk("rel_sinc", sincronizado, 0);
        chk("rel_err", error, 0);

        // Rejected word, then one word with fin during its data
        for (int i = 0; i < 18; i++) begin
            cyc(1'b0, tab[i].v, tab[i].d, tab[i].f);
            chk($sformatf("tab%0d_sout", i), s_out, tab[i].s);
            chk($sformatf("tab%0d_sinc", i), sincronizado, tab[i].y);
            chk($sformatf("tab%0d_listo", i), listo, tab[i].l);
            chk($sformatf("tab%0d_err", i), error, tab[i].e);
        end

        // Single word then filler
        do_reset();
        got = '0;
        cyc(1'b0, 1'b1, 5'b11001, 1'b0);
        got[19] = s_out;
        for (int i = 18; i >= 0; i--) begin
            cyc(1'b0, 1'b0, 5'd0, 1'b0);
            got[i] = s_out;
        end
        chk("single_word_stream", got, 20'b10100_11001_10100_10100);
        chk("single_word_sinc", sincronizado, 1);

        // Back-to-back words
        do_reset();
        got = '0;
        cyc(1'b0, 1'b1, 5'b11011, 1'b0);
        got[19] = s_out;
        chk("b2b_listo_full", listo, 0);
        for (int i = 18; i >= 15; i--) begin
            cyc(1'b0, 1'b0, 5'd0, 1'b0);
            got[i] = s_out;
        end
        cyc(1'b0, 1'b0, 5'd0, 1'b0);
        got[14] = s_out;
        chk("b2b_listo_free", listo, 1);
        cyc(1'b0, 1'b1, 5'b00110, 1'b0);
        got[13] = s_out;
        chk("b2b_listo_full2", listo, 0);
        for (int i = 12; i >= 0; i--) begin
            cyc(1'b0, 1'b0, 5'd0, 1'b0);
            got[i] = s_out;
        end
        chk("b2b_stream", got, 20'b10100_11011_00110_10100);

        // Asynchronous reset mid-data
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        m_reset();
        #1;
        chk("async_sout", s_out, 0);
        chk("async_sinc", sincronizado, 0);
        chk("async_listo", listo, 1);
        @(negedge clk);
        rst = 1'b0;
        got = '0;
        for (int i = 4; i >= 0; i--) begin
            cyc(1'b0, (i == 4), 5'b10101, 1'b0);
            got[i] = s_out;
        end
        chk("async_restart_hdr", got[4:0], 5'b10100);

        // Random stimulus against the model
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            logic r, v, f;
            logic [4:0] d;
            r = ($urandom_range(0, 199) == 0);
            v = ($urandom_range(0, 9) < 3);
            f = ($urandom_range(0, 19) == 0);
            d = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
            cyc(r, v, d, f);
            chk($sformatf("rnd%0d_sout", n), s_out, exp_s);
            chk($sformatf("rnd%0d_sinc", n), sincronizado, (mmode != 0));
            chk($sformatf("rnd%0d_listo", n), listo, m_listo());
            chk($sformatf("rnd%0d_err", n), error, exp_err);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/generador_trama.md
GENERADOR_TRAMA -- requirements
Module: generador_trama

Interface
REQ-001 SHALL have parameter SECUENCIA, default 5'b10100, sync/header codeword sent MSB first.
REQ-002 SHALL have parameter SEC_REINICIO, default 5'b00000, loss-of-sync codeword sent MSB first.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port dato_in  input  5  payload word to transmit.
REQ-006 SHALL have port dato_valido  input  1  dato_in is offered this cycle.
REQ-007 SHALL have port fin  input  1  request to end the stream with SEC_REINICIO.
REQ-008 SHALL have port listo  output  1  block can accept a word this cycle.
REQ-009 SHALL have port s_out  output  1  serial bit stream, registered.
REQ-010 SHALL have port sincronizado  output  1  stream active (header/data/reinicio in progress).
REQ-011 SHALL have port error  output  1  one-cycle pulse, offered word rejected.

Function
REQ-012 SHALL implement FSM states INACTIVO, SYNC, DATOS, REINICIO, plus a 3-bit bit index (4 down to 0), a 5-bit shift register, a one-entry word buffer and a fin_pend flag.
REQ-013 SHALL accept a word on a rising edge where dato_valido=1, listo=1 and dato_in != SEC_REINICIO; the accepted word goes into the buffer.
REQ-014 SHALL drive listo = buffer empty AND state != REINICIO, combinationally.
REQ-015 SHALL, when dato_valido=1, listo=1 and dato_in == SEC_REINICIO, discard the word, leave state and buffer unchanged, and assert error for exactly the following cycle.
REQ-016 SHALL, in INACTIVO, drive s_out=0 and sincronizado=0; an accepted word moves to SYNC at that edge.
REQ-017 SHALL hold every transmitted bit on s_out for exactly one clock, MSB first.
REQ-018 SHALL, for an acceptance at edge E0 in INACTIVO, present SECUENCIA[4..0] after edges E0..E4 and the word bits [4..0] after edges E5..E9, with no gaps.
REQ-019 SHALL, at the last bit of SYNC or DATOS, select the next action in this order:
- buffer full: load the buffer into the shift register, enter DATOS, free the buffer;
- else fin_pend: enter REINICIO;
- else: enter SYNC and transmit SECUENCIA as filler.
REQ-020 SHALL hold sincronizado=1 from the first SYNC bit through the last REINICIO bit.
REQ-021 SHALL, in REINICIO, transmit SEC_REINICIO[4..0], then enter INACTIVO, clear fin_pend and drive s_out=0.
REQ-022 SHALL latch fin=1 into fin_pend only in SYNC or DATOS; fin SHALL be ignored in INACTIVO and REINICIO.
REQ-023 SHALL, when fin and an accepted word occur on the same edge, transmit that word before REINICIO.
REQ-024 SHALL allow a word accepted during DATOS or filler SYNC to follow the current word back-to-back, with no filler between them.

Reset
REQ-025 SHALL, while rst=1, immediately force: state INACTIVO, s_out=0, listo=1, sincronizado=0, error=0, buffer empty, fin_pend=0, bit index=4.
REQ-026 SHALL, on rst asserted mid-stream, abandon the stream without sending SEC_REINICIO; the next acceptance after release SHALL restart with a full header.

Verification
REQ-027 SHALL cover: rst=1 at time 0, then release -> s_out=0, listo=1, sincronizado=0, error=0.
REQ-028 SHALL cover: dato_in=5'b11001 accepted in INACTIVO, no further input -> s_out 1,0,1,0,0,1,1,0,0,1, then filler 1,0,1,0,0 repeating; sincronizado=1.
REQ-029 SHALL cover: 5'b11011 accepted, then 5'b00110 offered on the first DATOS cycle -> s_out 10100 11011 00110 contiguous, then filler; listo=0 while the buffer is full.
REQ-030 SHALL cover: one word 5'b01110 accepted, fin pulsed during its DATOS -> s_out 10100 01110 00000, then s_out=0, sincronizado=0, listo=1.
REQ-031 SHALL cover: dato_in=5'b00000 with dato_valido=1 in INACTIVO -> error=1 for one cycle, state stays INACTIVO, s_out=0.
REQ-032 SHALL cover: rst=1 asserted mid-DATOS -> s_out=0 and sincronizado=0 without waiting for clk; next accepted word is preceded by 10100.
